pixel_draw_queue: RTL and testbench



---
 rtl/pixel_draw_queue_if.sv | 22 ++
 rtl/pixel_draw_queue.sv | 168 ++++++++++++++++
 tb/tb_pixel_draw_queue.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_draw_queue_if.sv
// Command bus into pixel_draw_queue: one pixel or one rectangle fill per accepted beat.
// A beat transfers on a rising clk edge where cmd_valid & cmd_ready; fields must stay stable while valid is high and not yet accepted.
interface pixel_draw_queue_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_fill;
   logic [7:0] cmd_x0;
   logic [6:0] cmd_y0;
   logic [7:0] cmd_x1;
   logic [6:0] cmd_y1;
   logic [2:0] cmd_colour;

   modport master (
      output cmd_valid, cmd_fill, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_fill, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour,
      output cmd_ready
   );
endinterface

// File: rtl/pixel_draw_queue.sv
// Command FIFO plus raster engine feeding vga_adapter one pixel per cycle.
// Pixel and fill commands are queued, then expanded into x/y/colour/plot writes with clipping.
module pixel_draw_queue #(
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic                 clk,
   input  logic                 resetn,
   pixel_draw_queue_if.slave    cmd,
   output logic [7:0]           x_out,
   output logic [6:0]           y_out,
   output logic [2:0]           colour,
   output logic                 plot,
   output logic                 busy,
   output logic [1:0]           o_dbg_state,
   output logic [ADDR_W:0]      o_dbg_count
);

   typedef struct packed {
      logic       fill;
      logic [7:0] x0;
      logic [6:0] y0;
      logic [7:0] x1;
      logic [6:0] y1;
      logic [2:0] colour;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PIXEL = 2'd1,
      S_FILL  = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

   cmd_t              r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;

   state_t            r_state;
   logic [7:0]        r_cur_x;
   logic [6:0]        r_cur_y;
   logic [7:0]        r_x0;
   logic [7:0]        r_x1;
   logic [6:0]        r_y1;
   logic [2:0]        r_col;
   logic              r_degen;

   logic [7:0]        r_x_out;
   logic [6:0]        r_y_out;
   logic [2:0]        r_col_out;
   logic              r_plot;

   cmd_t              w_in;
   cmd_t              w_head;
   logic              w_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_row_end;
   logic              w_last;
   logic              w_done;
   logic              w_on;
   logic              w_emit;

   assign w_in = {cmd.cmd_fill, cmd.cmd_x0, cmd.cmd_y0, cmd.cmd_x1, cmd.cmd_y1, cmd.cmd_colour};
   assign w_head = r_mem[r_rd_ptr];

   assign w_ready = (r_count < L_DEPTH);
   assign w_push  = cmd.cmd_valid & w_ready;

   // The engine finishes a command this edge, so it may take the next head in the same edge.
   assign w_row_end = (r_cur_x == r_x1);
   assign w_last    = r_degen | (w_row_end & (r_cur_y == r_y1));
   assign w_done    = (r_state == S_IDLE) | (r_state == S_PIXEL) | ((r_state == S_FILL) & w_last);
   assign w_pop     = (r_count != '0) & w_done;

   // Widened compares so off-screen coordinates never alias back on-screen.
   assign w_on   = ({1'b0, r_cur_x} < 9'(SCREEN_W)) & ({1'b0, r_cur_y} < 8'(SCREEN_H));
   assign w_emit = (r_state != S_IDLE) & ~r_degen & w_on;

   always_ff @(posedge clk) begin
      if (resetn && w_push) begin
         r_mem[r_wr_ptr] <= w_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_cur_x   <= '0;
         r_cur_y   <= '0;
         r_x0      <= '0;
         r_x1      <= '0;
         r_y1      <= '0;
         r_col     <= '0;
         r_degen   <= 1'b0;
         r_x_out   <= '0;
         r_y_out   <= '0;
         r_col_out <= '0;
         r_plot    <= 1'b0;
      end else begin
         r_plot <= 1'b0;
         if (w_emit) begin
            r_plot    <= 1'b1;
            r_x_out   <= r_cur_x;
            r_y_out   <= r_cur_y;
            r_col_out <= r_col;
         end

         if ((r_state == S_FILL) && !w_last) begin
            if (w_row_end) begin
               r_cur_x <= r_x0;
               r_cur_y <= r_cur_y + 1'b1;
            end else begin
               r_cur_x <= r_cur_x + 1'b1;
            end
         end

         if (w_pop) begin
            r_cur_x <= w_head.x0;
            r_cur_y <= w_head.y0;
            r_x0    <= w_head.x0;
            r_x1    <= w_head.x1;
            r_y1    <= w_head.y1;
            r_col   <= w_head.colour;
            // An empty rectangle still spends one cycle in FILL, emitting nothing.
            r_degen <= w_head.fill & ((w_head.x1 < w_head.x0) | (w_head.y1 < w_head.y0));
            r_state <= w_head.fill ? S_FILL : S_PIXEL;
         end else if (w_done) begin
            r_degen <= 1'b0;
            r_state <= S_IDLE;
         end
      end
   end

   assign cmd.cmd_ready = w_ready;
   assign x_out         = r_x_out;
   assign y_out         = r_y_out;
   assign colour        = r_col_out;
   assign plot          = r_plot;
   assign busy          = (r_count != '0) | (r_state != S_IDLE);
   assign o_dbg_state   = r_state;
   assign o_dbg_count   = r_count;

endmodule

// File: tb/tb_pixel_draw_queue.sv
// Directed bench for pixel_draw_queue: latency, raster order, backpressure, clipping and reset abort.
module tb_pixel_draw_queue;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic [1:0] dbg_state;
   logic [3:0] dbg_count;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [17:0] pix_q[$];
   int          cyc_q[$];
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   pixel_draw_queue_if cmd_if ();

   pixel_draw_queue dut (
      .clk         (clk),
      .resetn      (resetn),
      .cmd         (cmd_if.slave),
      .x_out       (x_out),
      .y_out       (y_out),
      .colour      (colour),
      .plot        (plot),
      .busy        (busy),
      .o_dbg_state (dbg_state),
      .o_dbg_count (dbg_count)
   );

   // Log every plotted pixel with the cycle it appeared in.
   always @(negedge clk) begin
      if (resetn && plot) begin
         pix_q.push_back({x_out, y_out, colour});
         cyc_q.push_back(cyc);
      end
      cyc++;
   end

   function automatic logic [17:0] pw(input int x, input int y, input int c);
      return {8'(x), 7'(y), 3'(c)};
   endfunction

   task automatic add_fill(input int x0, input int y0, input int x1, input int y1, input int c);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            if (x < 160 && y < 120) exp_q.push_back(pw(x, y, c));
   endtask

   task automatic clear_logs();
      pix_q.delete();
      cyc_q.delete();
      exp_q.delete();
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic f, input logic [7:0] x0, input logic [6:0] y0,
                       input logic [7:0] x1, input logic [6:0] y1, input logic [2:0] c,
                       output int stalls);
      logic acc;
      acc = 1'b0;
      stalls = 0;
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_fill   = f;
      cmd_if.cmd_x0     = x0;
      cmd_if.cmd_y0     = y0;
      cmd_if.cmd_x1     = x1;
      cmd_if.cmd_y1     = y1;
      cmd_if.cmd_colour = c;
      for (int i = 0; i < 2000; i++) begin
         acc = cmd_if.cmd_ready;
         @(negedge clk);
         if (acc) break;
         stalls++;
      end
      cmd_if.cmd_valid = 1'b0;
      tests++;
      if (!acc) begin
         fails++;
         $display("FAIL push_accept: cmd_ready stayed %0b for %0d cycles, required 1", acc, stalls);
      end
   endtask

   task automatic wait_idle(input int max_cycles);
      logic done;
      done = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, max_cycles);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_fill   = 1'b0;
      cmd_if.cmd_x0     = 8'd5;
      cmd_if.cmd_y0     = 7'd5;
      cmd_if.cmd_x1     = 8'd0;
      cmd_if.cmd_y1     = 7'd0;
      cmd_if.cmd_colour = 3'd4;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (plot !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold: plot=%b busy=%b, required 0 0", plot, busy);
      end
      cmd_if.cmd_valid = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      tests++;
      if (cmd_if.cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_if.cmd_ready);
      end
      tests++;
      if (x_out !== 8'd0 || y_out !== 7'd0 || colour !== 3'd0) begin
         fails++;
         $display("FAIL reset_outputs: x=%0d y=%0d c=%0d, required 0 0 0", x_out, y_out, colour);
      end
      tests++;
      if (dbg_count !== 4'd0 || dbg_state !== 2'd0) begin
         fails++;
         $display("FAIL reset_state: count=%0d state=%0d, required 0 0", dbg_count, dbg_state);
      end
      repeat (5) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || pix_q.size() != 0) begin
         fails++;
         $display("FAIL reset_ignored: busy=%b plots=%0d, required 0 0", busy, pix_q.size());
      end
   endtask

   task automatic test_single_pixel();
      int st;
      clear_logs();
      push(1'b0, 8'd80, 7'd60, 8'd0, 7'd0, 3'b001, st);
      tests++;
      if (busy !== 1'b1 || plot !== 1'b0) begin
         fails++;
         $display("FAIL single_e0: busy=%b plot=%b, required 1 0", busy, plot);
      end
      @(negedge clk);
      tests++;
      if (plot !== 1'b0) begin
         fails++;
         $display("FAIL single_e1: plot=%b, required 0", plot);
      end
      @(negedge clk);
      tests++;
      if (plot !== 1'b1 || x_out !== 8'd80 || y_out !== 7'd60 || colour !== 3'd1) begin
         fails++;
         $display("FAIL single_e2: plot=%b x=%0d y=%0d c=%0d, required 1 80 60 1", plot, x_out, y_out, colour);
      end
      @(negedge clk);
      tests++;
      if (plot !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL single_e3: plot=%b busy=%b, required 0 0", plot, busy);
      end
   endtask

   task automatic test_arena_fill();
      int st;
      int bad;
      int span;
      clear_logs();
      push(1'b1, 8'd48, 7'd28, 8'd112, 7'd92, 3'd7, st);
      add_fill(48, 28, 112, 92, 7);
      wait_idle(5000);
      tests++;
      if (pix_q.size() != 4225) begin
         fails++;
         $display("FAIL arena_count: plots=%0d, required 4225", pix_q.size());
      end
      if (pix_q.size() == 4225) begin
         tests++;
         if (pix_q[0] !== pw(48, 28, 7) || pix_q[64] !== pw(112, 28, 7) ||
             pix_q[65] !== pw(48, 29, 7) || pix_q[4224] !== pw(112, 92, 7)) begin
            fails++;
            $display("FAIL arena_corners: got %h %h %h %h, required %h %h %h %h",
                     pix_q[0], pix_q[64], pix_q[65], pix_q[4224],
                     pw(48, 28, 7), pw(112, 28, 7), pw(48, 29, 7), pw(112, 92, 7));
         end
         bad = -1;
         for (int i = 0; i < 4225; i++)
            if (bad < 0 && pix_q[i] !== exp_q[i]) bad = i;
         tests++;
         if (bad >= 0) begin
            fails++;
            $display("FAIL arena_order: idx %0d got %h, required %h", bad, pix_q[bad], exp_q[bad]);
         end
         span = cyc_q[4224] - cyc_q[0];
         tests++;
         if (span != 4224) begin
            fails++;
            $display("FAIL arena_contiguous: span=%0d, required 4224", span);
         end
      end
   endtask

   task automatic test_backpressure();
      int st;
      int bad;
      int span;
      clear_logs();
      push(1'b1, 8'd0, 7'd0, 8'd9, 7'd9, 3'd2, st);
      add_fill(0, 0, 9, 9, 2);
      for (int i = 0; i < 8; i++) begin
         push(1'b0, 8'(20 + i), 7'd5, 8'd0, 7'd0, 3'(i), st);
         exp_q.push_back(pw(20 + i, 5, i));
      end
      tests++;
      if (cmd_if.cmd_ready !== 1'b0 || dbg_count !== 4'd8) begin
         fails++;
         $display("FAIL bp_full: cmd_ready=%b count=%0d, required 0 8", cmd_if.cmd_ready, dbg_count);
      end
      push(1'b0, 8'd28, 7'd5, 8'd0, 7'd0, 3'd0, st);
      exp_q.push_back(pw(28, 5, 0));
      tests++;
      if (st == 0) begin
         fails++;
         $display("FAIL bp_stall: stalled %0d cycles, required more than 0", st);
      end
      wait_idle(500);
      tests++;
      if (pix_q.size() != 109) begin
         fails++;
         $display("FAIL bp_count: plots=%0d, required 109", pix_q.size());
      end
      if (pix_q.size() == 109) begin
         bad = -1;
         for (int i = 0; i < 109; i++)
            if (bad < 0 && pix_q[i] !== exp_q[i]) bad = i;
         tests++;
         if (bad >= 0) begin
            fails++;
            $display("FAIL bp_order: idx %0d got %h, required %h", bad, pix_q[bad], exp_q[bad]);
         end
         span = cyc_q[108] - cyc_q[0];
         tests++;
         if (span != 108) begin
            fails++;
            $display("FAIL bp_contiguous: span=%0d, required 108", span);
         end
      end
   endtask

   task automatic test_clip_degen();
      int st;
      clear_logs();
      push(1'b1, 8'd158, 7'd119, 8'd161, 7'd119, 3'd5, st);
      push(1'b1, 8'd10, 7'd0, 8'd5, 7'd0, 3'd4, st);
      push(1'b0, 8'd3, 7'd4, 8'd0, 7'd0, 3'd6, st);
      wait_idle(100);
      tests++;
      if (pix_q.size() != 3) begin
         fails++;
         $display("FAIL clip_count: plots=%0d, required 3", pix_q.size());
      end
      if (pix_q.size() == 3) begin
         tests++;
         if (pix_q[0] !== pw(158, 119, 5) || pix_q[1] !== pw(159, 119, 5) || pix_q[2] !== pw(3, 4, 6)) begin
            fails++;
            $display("FAIL clip_pixels: got %h %h %h, required %h %h %h", pix_q[0], pix_q[1], pix_q[2],
                     pw(158, 119, 5), pw(159, 119, 5), pw(3, 4, 6));
         end
         // Two clipped cycles plus one degenerate cycle separate the last fill plot from the pixel.
         tests++;
         if (cyc_q[1] - cyc_q[0] != 1 || cyc_q[2] - cyc_q[1] != 4) begin
            fails++;
            $display("FAIL clip_timing: gaps %0d %0d, required 1 4", cyc_q[1] - cyc_q[0], cyc_q[2] - cyc_q[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int st;
      int bad;
      int span;
      clear_logs();
      push(1'b1, 8'd0, 7'd50, 8'd6, 7'd50, 3'd3, st);
      add_fill(0, 50, 6, 50, 3);
      for (int i = 0; i < 7; i++) begin
         push(1'b0, 8'(40 + i), 7'd10, 8'd0, 7'd0, 3'(i), st);
         exp_q.push_back(pw(40 + i, 10, i));
      end
      tests++;
      if (dbg_count !== 4'd7) begin
         fails++;
         $display("FAIL b2b_pre_count: count=%0d, required 7", dbg_count);
      end
      push(1'b0, 8'd47, 7'd10, 8'd0, 7'd0, 3'd7, st);
      exp_q.push_back(pw(47, 10, 7));
      tests++;
      if (dbg_count !== 4'd7 || st != 0) begin
         fails++;
         $display("FAIL b2b_pushpop: count=%0d stalls=%0d, required 7 0", dbg_count, st);
      end
      wait_idle(100);
      tests++;
      if (pix_q.size() != 15) begin
         fails++;
         $display("FAIL b2b_count: plots=%0d, required 15", pix_q.size());
      end
      if (pix_q.size() == 15) begin
         bad = -1;
         for (int i = 0; i < 15; i++)
            if (bad < 0 && pix_q[i] !== exp_q[i]) bad = i;
         tests++;
         if (bad >= 0) begin
            fails++;
            $display("FAIL b2b_order: idx %0d got %h, required %h", bad, pix_q[bad], exp_q[bad]);
         end
         span = cyc_q[14] - cyc_q[0];
         tests++;
         if (span != 14) begin
            fails++;
            $display("FAIL b2b_contiguous: span=%0d, required 14", span);
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      int st;
      int n_after;
      logic reached;
      clear_logs();
      push(1'b1, 8'd48, 7'd28, 8'd112, 7'd92, 3'd7, st);
      push(1'b0, 8'd1, 7'd1, 8'd0, 7'd0, 3'd1, st);
      push(1'b0, 8'd2, 7'd2, 8'd0, 7'd0, 3'd2, st);
      push(1'b0, 8'd3, 7'd3, 8'd0, 7'd0, 3'd3, st);
      reached = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (pix_q.size() >= 499) begin
            reached = 1'b1;
            break;
         end
      end
      tests++;
      if (!reached) begin
         fails++;
         $display("FAIL rst_mid_reach: plots=%0d, required 499", pix_q.size());
      end
      resetn = 1'b0;
      @(negedge clk);
      tests++;
      if (plot !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_edge: plot=%b busy=%b, required 0 0", plot, busy);
      end
      tests++;
      if (dbg_count !== 4'd0 || dbg_state !== 2'd0 || x_out !== 8'd0) begin
         fails++;
         $display("FAIL rst_mid_flush: count=%0d state=%0d x=%0d, required 0 0 0", dbg_count, dbg_state, x_out);
      end
      n_after = pix_q.size();
      resetn = 1'b1;
      repeat (30) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || pix_q.size() != n_after) begin
         fails++;
         $display("FAIL rst_mid_after: busy=%b plots=%0d, required 0 %0d", busy, pix_q.size(), n_after);
      end
   endtask

   initial begin
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_fill   = 1'b0;
      cmd_if.cmd_x0     = 8'd0;
      cmd_if.cmd_y0     = 7'd0;
      cmd_if.cmd_x1     = 8'd0;
      cmd_if.cmd_y1     = 7'd0;
      cmd_if.cmd_colour = 3'd0;
      test_reset();
      test_single_pixel();
      test_arena_fill();
      test_backpressure();
      test_clip_degen();
      test_back_to_back();
      test_reset_mid_fill();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
